// File: rtl/cic_pkg.sv
// cic_pkg: sequencer encodings, PDM mapping and sizing helpers shared by the CIC decimator.
package cic_pkg;
  typedef enum logic {CIC_SEQ_IDLE = 1'b0, CIC_SEQ_RUN = 1'b1} cic_seq_t;
  localparam logic signed [1:0] PDM_HI = 2'sb01;
  localparam logic signed [1:0] PDM_LO = 2'sb11;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int acc_w(input int order, input int decim);
    return 2 + order * clog2(decim);
  endfunction
endpackage

// File: rtl/cic_comb_pipe.sv
// cic_comb_pipe: time-multiplexed CIC comb chain with per-channel delays, latency ORDER+1.
module cic_comb_pipe import cic_pkg::*; #(
  parameter int ORDER = 4,
  parameter int CHANNELS = 16,
  parameter int ACC_W = 26,
  localparam int CW = clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CW-1:0]    in_chan,
  input  logic [ACC_W-1:0] in_data,
  output logic             out_valid,
  output logic [CW-1:0]    out_chan,
  output logic [ACC_W-1:0] out_data
);
  logic [ORDER:0]   v;
  logic [CW-1:0]    c [ORDER+1];
  logic [ACC_W-1:0] d [ORDER+1];
  logic [ACC_W-1:0] dly [ORDER][CHANNELS];
  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      c   <= '{default: '0};
      d   <= '{default: '0};
      dly <= '{default: '{default: '0}};
    end else begin
      v    <= {v[ORDER-1:0], in_valid};
      c[0] <= in_chan;
      d[0] <= in_data;
      for (int j = 0; j < ORDER; j++) begin
        c[j+1] <= c[j];
        d[j+1] <= d[j] - dly[j][c[j]];
        if (v[j]) dly[j][c[j]] <= d[j];
      end
    end
  end
  assign out_valid = v[ORDER];
  assign out_chan  = c[ORDER];
  assign out_data  = d[ORDER];
endmodule

// File: rtl/cic_decimator_mc.sv
// cic_decimator_mc: multi-channel PDM CIC decimator with per-channel integrators and a shared comb pipe.
module cic_decimator_mc import cic_pkg::*; #(
  parameter int CHANNELS = 16,
  parameter int ORDER = 4,
  parameter int DECIM = 64,
  parameter int OUT_W = 19,
  localparam int ACC_W = acc_w(ORDER, DECIM),
  localparam int CW = clog2(CHANNELS),
  localparam int DW = clog2(DECIM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pdm_valid,
  input  logic [CHANNELS-1:0] pdm_in,
  output logic                out_valid,
  output logic [CW-1:0]       out_chan,
  output logic [OUT_W-1:0]    out_data,
  output logic                overrun
);
  logic [ACC_W-1:0] integ    [CHANNELS][ORDER];
  logic [ACC_W-1:0] integ_nx [CHANNELS][ORDER];
  logic [ACC_W-1:0] shadow   [CHANNELS];
  logic [ACC_W-1:0] acc;
  logic [DW-1:0]    dcnt;
  logic [CW-1:0]    seq_chan;
  cic_seq_t         state, state_nx;
  logic             snap, snap_take, last_chan;
  logic             p_valid;
  logic [CW-1:0]    p_chan;
  logic [ACC_W-1:0] p_data;
  logic             unused_lsbs;
  // Integrator chain ripples within the strobe so the snapshot includes the current sample.
  always_comb begin
    acc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      acc = ACC_W'(pdm_in[c] ? PDM_HI : PDM_LO);
      for (int i = 0; i < ORDER; i++) begin
        acc = integ[c][i] + acc;
        integ_nx[c][i] = acc;
      end
    end
  end
  assign snap      = pdm_valid && dcnt == DW'(DECIM - 1);
  assign last_chan = seq_chan == CW'(CHANNELS - 1);
  always_comb begin
    snap_take = snap && state == CIC_SEQ_IDLE;
    state_nx  = snap_take ? CIC_SEQ_RUN : (state == CIC_SEQ_RUN && last_chan) ? CIC_SEQ_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      integ    <= '{default: '{default: '0}};
      shadow   <= '{default: '0};
      dcnt     <= '0;
      seq_chan <= '0;
      state    <= CIC_SEQ_IDLE;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nx;
      seq_chan <= (state == CIC_SEQ_RUN && !last_chan) ? seq_chan + 1'b1 : '0;
      if (pdm_valid) begin
        integ <= integ_nx;
        dcnt  <= dcnt + 1'b1;
      end
      if (snap_take) for (int c = 0; c < CHANNELS; c++) shadow[c] <= integ_nx[c][ORDER-1];
      if (snap && state == CIC_SEQ_RUN) overrun <= 1'b1;
    end
  end
  cic_comb_pipe #(.ORDER(ORDER), .CHANNELS(CHANNELS), .ACC_W(ACC_W)) u_comb (
    .clk(clk), .rst(rst),
    .in_valid(state == CIC_SEQ_RUN), .in_chan(seq_chan), .in_data(shadow[seq_chan]),
    .out_valid(p_valid), .out_chan(p_chan), .out_data(p_data)
  );
  assign out_valid   = p_valid;
  assign out_chan    = p_chan;
  assign out_data    = p_data[ACC_W-1 -: OUT_W];
  assign unused_lsbs = ^p_data;
endmodule

// File: tb/tb_cic_decimator_mc.sv
// tb_cic_decimator_mc: randomized scoreboard bench against a direct-convolution CIC reference model.
module tb_cic_decimator_mc;
  localparam int CH = 16, N = 4, D = 64, OW = 19, AW = 26, SH = AW - OW, LAT = N + 2;
  localparam int HL = N * (D - 1) + 1, D8 = 8, AW8 = 14;
  typedef struct { int chan; longint data; int cyc; bit tol; } exp_t;
  logic clk = 0, rst = 1, pdm_valid = 0;
  logic [CH-1:0] pdm_in = '0;
  logic out_valid, overrun;
  logic [3:0] out_chan;
  logic [OW-1:0] out_data;
  logic rst8 = 1, pv8 = 0, ov8, orun8;
  logic [CH-1:0] pin8 = '0;
  logic [3:0] oc8;
  logic [AW8-1:0] od8;
  int total = 0, bad = 0, cyc = 0, mode = 0;
  int frames8 = 0, next8 = 0, last8_cyc = -1;
  exp_t sb[$];
  logic [CH-1:0] hist[$];
  longint h [HL];

  cic_decimator_mc dut (.clk(clk), .rst(rst), .pdm_valid(pdm_valid), .pdm_in(pdm_in),
    .out_valid(out_valid), .out_chan(out_chan), .out_data(out_data), .overrun(overrun));
  cic_decimator_mc #(.CHANNELS(CH), .ORDER(4), .DECIM(D8), .OUT_W(AW8)) dut8 (.clk(clk), .rst(rst8),
    .pdm_valid(pv8), .pdm_in(pin8), .out_valid(ov8), .out_chan(oc8), .out_data(od8), .overrun(orun8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req, input longint tol = 0);
    total++;
    if (act > req + tol || act < req - tol) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [CH-1:0] gen(input int m, input int s);
    logic [CH-1:0] b;
    for (int k = 0; k < CH; k++)
      b[k] = m == 0 ? 1'b1 : m == 1 ? 1'b0 : m == 2 ? ~s[0] : m == 3 ? ((s % 16) < k) : 1'($urandom);
    return b;
  endfunction

  function automatic longint steady(input int m, input int k);
    return m == 0 ? 131072 : m == 1 ? -131072 : m == 2 ? 0 : 131072 * (2 * k - 16) / 16;
  endfunction

  // Output of frame m is the CIC impulse response applied to all strobes since reset.
  task automatic model_frame();
    int s, m;
    longint y;
    s = hist.size() - 1;
    m = s / D;
    for (int k = 0; k < CH; k++) begin
      y = 0;
      for (int i = 0; i < HL && i <= s; i++) y += h[i] * (hist[s-i][k] ? 1 : -1);
      sb.push_back(exp_t'{k, (m >= N && mode < 4) ? steady(mode, k) : (y >>> SH), cyc + LAT + k, mode == 3});
    end
  endtask

  task automatic step(input bit v, input logic [CH-1:0] b);
    @(posedge clk); #1;
    pdm_valid = v;
    pdm_in = b;
    if (v) begin
      hist.push_back(b);
      if (hist.size() % D == 0) model_frame();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    pdm_valid = 0;
    @(posedge clk); #1;
    check("rst_valid", out_valid, 0);
    check("rst_chan", out_chan, 0);
    check("rst_data", out_data, 0);
    check("rst_overrun", overrun, 0);
    rst = 0;
    sb.delete();
    hist.delete();
  endtask

  task automatic drain();
    repeat (LAT + CH + 6) step(0, '0);
    check("drain_pending", sb.size(), 0);
  endtask

  task automatic run_phase(input int m, input int frames, input bit gaps);
    do_reset();
    mode = m;
    for (int s = 0; s < frames * D; s++) begin
      while (gaps && $urandom_range(3) == 0) step(0, '0);
      step(1, gen(m, s));
    end
    drain();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: chan %0d data %0d with nothing expected", out_chan, $signed(out_data));
        end else begin
          e = sb.pop_front();
          check("out_chan", out_chan, e.chan);
          check("out_data", longint'($signed(out_data)), e.data, e.tol ? 1 : 0);
          check("out_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (ov8) begin
      check("frame8_chan", oc8, next8);
      if (oc8 != 0) check("frame8_gap", cyc, last8_cyc + 1);
      if (oc8 == 4'(CH - 1)) frames8++;
      next8 = (int'(oc8) + 1) % CH;
      last8_cyc = cyc;
    end
  end

  initial begin
    longint t [HL];
    int w;
    h = '{default: 0};
    for (int i = 0; i < D; i++) h[i] = 1;
    repeat (N - 1) begin
      t = h;
      for (int i = 0; i < HL; i++) begin
        h[i] = 0;
        for (int j = 0; j < D && j <= i; j++) h[i] += t[i-j];
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("init_valid", out_valid, 0);
    check("init_data", out_data, 0);
    check("init_overrun", overrun, 0);
    rst = 0;
    run_phase(0, 7, 0);
    run_phase(1, 6, 0);
    run_phase(2, 6, 0);
    run_phase(3, 6, 0);
    run_phase(4, 6, 1);
    do_reset();
    mode = 4;
    for (int s = 0; s < 3 * D; s++) step(1, gen(4, s));
    w = 0;
    while (w < 40) begin
      @(posedge clk); #1;
      pdm_valid = 0;
      if (out_valid && out_chan == 7) break;
      w++;
    end
    check("rst_wait", w < 40, 1);
    rst = 1;
    @(posedge clk); #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_chan", out_chan, 0);
    check("midrst_data", out_data, 0);
    sb.delete();
    hist.delete();
    rst = 0;
    for (int s = 0; s < 6 * D; s++) step(1, gen(4, s));
    drain();
    check("overrun_main", overrun, 0);
    @(posedge clk); #1;
    check("rst8_valid", ov8, 0);
    check("rst8_overrun", orun8, 0);
    rst8 = 0;
    for (int s = 0; s < 12 * D8; s++) begin
      @(posedge clk); #1;
      if (s == 15) check("orun8_before", orun8, 0);
      if (s == 16) check("orun8_after", orun8, 1);
      pv8 = 1;
      pin8 = gen(4, s);
    end
    @(posedge clk); #1;
    pv8 = 0;
    repeat (30) @(posedge clk);
    #1;
    check("orun8_sticky", orun8, 1);
    check("frames8", frames8, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cic_decimator_mc.md
# cic_decimator_mc

Multi-channel, parametrised CIC decimator for the PDM microphone array front end. It accepts one PDM bit per channel on a qualified strobe and runs per-channel integrators at the PDM rate. It decimates by `DECIM` and streams one signed PCM word per channel through a single time-multiplexed comb pipeline to the downstream beamformer. It runs on one system clock; the decimation timing comes from an internal counter rather than a second clock.

## Interface
Parameters:
- `CHANNELS`, 16: number of microphone channels.
- `ORDER`, 4: CIC order, i.e. the number of integrator and comb stages (1..6).
- `DECIM`, 64: decimation ratio, a power of two from 8 to 256.
- `OUT_W`, 19: output word width; must satisfy `OUT_W` ≤ `ACC_W`.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `pdm_valid`, input, 1: qualifies `pdm_in`. At most one strobe per cycle.
- `pdm_in`, input, `CHANNELS`: one PDM bit per channel. Bit k is channel k.
- `out_valid`, output, 1: high for one cycle per output word.
- `out_chan`, output, clog2(`CHANNELS`): channel index of `out_data`.
- `out_data`, output, `OUT_W`: signed PCM sample.
- `overrun`, output, 1: sticky flag, set when a decimation frame is dropped.

## Operation
- Input mapping: PDM bit 0 maps to −1 and bit 1 maps to +1, each as a 2-bit signed value.
- Accumulator width: `ACC_W` = 2 + `ORDER`·log2(`DECIM`). All integrator, comb and delay registers are `ACC_W` bits wide, two's complement.
- Wrap-around: overflow inside integrators is intentional. Modular arithmetic makes the comb result exact, so no saturation is applied anywhere.
- Integrators: `CHANNELS` × `ORDER` chains in parallel. They update only in cycles where `pdm_valid` is high.
- Decimation counter: counts `pdm_valid` strobes from 0 to `DECIM`−1, then wraps.
- Snapshot: on the strobe where the counter is at `DECIM`−1, the last integrator stage of every channel (including that sample) is copied into a shadow array, and the sequencer is started.
- Sequencer: two states.
  - IDLE: moves to RUN on a snapshot.
  - RUN: feeds the shadow value for channels 0..`CHANNELS`−1, one per cycle, into the comb pipeline. Returns to IDLE after the last channel is issued.
- Comb pipeline: `ORDER` stages, with per-channel delay registers indexed by channel.
  - Stage j output = x − delay[j][chan].
  - delay[j][chan] is updated with x.
- Output word: bits [`ACC_W`−1 : `ACC_W`−`OUT_W`] of the final comb output. This is a truncating arithmetic shift right by `ACC_W`−`OUT_W`.
- Overrun: if a snapshot is due while the sequencer is in RUN, that snapshot is dropped and `overrun` is set.
  - Integrators and the decimation counter keep running.
  - The shadow array is not overwritten.
  - `overrun` clears only on `rst`.
- Start-up: frames 0..`ORDER`−1 after reset are the CIC transient. Output is steady from frame `ORDER` onward.
- Reset:
  - `rst` clears integrators, delays, shadow, counter, sequencer (to IDLE), `out_valid`, `out_chan`, `out_data` and `overrun`, all to 0.
  - A frame in flight is abandoned; no partial words are emitted after reset.

## Timing
- Let T be the cycle in which `pdm_valid` is high and the counter is at `DECIM`−1.
  - The shadow array is loaded at the end of T.
  - Channel k appears with `out_valid`=1 in cycle T+`ORDER`+2+k.
- A frame is `CHANNELS` consecutive valid cycles with `out_chan` running 0,1,…,`CHANNELS`−1. There are no gaps.
- Requirement for no overrun: at least `CHANNELS`+1 system cycles between successive snapshots. With the defaults this means ≥17 clk cycles per 64 strobes.
- No backpressure: the downstream consumer must accept every valid word.
- Simultaneous events:
  - A `pdm_valid` during RUN is absorbed by the integrators and never stalls the sequencer.
  - `rst` overrides everything in the same cycle.

## Structure
- Package `cic_pkg`:
  - `clog2` function.
  - `acc_w(order, decim)` function.
  - `CIC_SEQ_IDLE` and `CIC_SEQ_RUN` state encodings.
  - PDM-to-signed mapping constant.
- Sub-module `cic_comb_pipe`:
  - Parameters: `ORDER`, `CHANNELS`, `ACC_W`.
  - Ports: in_valid, in_chan, in_data → out_valid, out_chan, out_data.
  - Holds the per-channel delay arrays and has `ORDER`+1 cycles of latency.
- The top level holds the integrators, decimation counter, shadow array, sequencer, output truncation and `overrun`.

## Test plan
- All channels held at 1, `pdm_valid` every cycle, defaults: from frame 4 onward every `out_data` = +131072, `out_chan` runs 0..15, `overrun`=0.
- All channels at 0: steady `out_data` = −131072. Alternating 1,0 bit pattern: steady `out_data` = 0.
- Per-channel distinct patterns (channel k outputs 1 on k/16 of strobes): steady `out_data`[k] = 131072·(2k−16)/16 ±1 LSB, which checks channel ordering and that channels do not mix.
- `pdm_valid` every cycle with `CHANNELS`=16 and `DECIM`=8: `overrun` rises at the second snapshot and stays set; the words that are emitted belong to complete, non-interleaved frames.
- Assert `rst` during the channel-7 output of a frame: `out_valid`=0 from the next cycle, all outputs are 0, and the next frame after release matches the from-reset transient exactly.
- Latency check: the first snapshot strobe at cycle T gives channel 0 valid in exactly T+6 with `ORDER`=4.
